crc_engine_param: RTL and testbench

- Parametrised successor to the team's serial CRC-8 block.
- Computes a generic CRC over a framed input stream, DATA_W bits per clock; the frame is delimited by ACTIVE.
- Reseeds automatically at each frame start, so no reset is needed between messages.
- Presents the final CRC in parallel with a one-cycle Valid pulse, then shifts it out serially for link-level transmission.

---
 rtl/crc_engine_param.sv | 143 ++++++++++++++
 tb/tb_crc_engine_param.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_engine_param.sv
// crc_engine_param
// Framed, parametrised CRC engine (Galois form). It consumes DATA_W bits per
// clock while ACTIVE is high, bit 0 first, and reseeds at every frame start.
// When the frame ends it presents the result on CRC with a one-cycle Valid
// pulse, then shifts the result out MSB first on SER_OUT / SER_VALID.
//
// Build option: define CRC_FINAL_XOR_EN to present CRC and SER_OUT inverted
// (crc_reg XOR all-ones). The internal register and the timing do not change.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no frame in progress; CRC holds the last result (or SEED)
// S_CALC  | frame in progress; crc_reg absorbs DATA every ACTIVE cycle
// S_SHIFT | frame done; result shifted out MSB first, CRC held

module crc_engine_param #(
    parameter int               CRC_W  = 8,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'('h07),
    parameter logic [CRC_W-1:0] SEED   = CRC_W'('h00),
    parameter int               DATA_W = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DATA,
    input  logic              ACTIVE,
    output logic [CRC_W-1:0]  CRC,
    output logic              Valid,
    output logic              SER_OUT,
    output logic              SER_VALID
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    // Enough bits to index every CRC bit; CRC_W >= 2 keeps this at least 1.
    localparam int               CNT_W    = $clog2(CRC_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 1);

    state_t           r_state;
    logic [CRC_W-1:0] r_crc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic             r_ser_out;
    logic             r_ser_valid;

    logic [CRC_W-1:0] w_base;
    logic [CRC_W-1:0] w_step;
    logic [CRC_W-1:0] w_crc_out;
    logic [CNT_W-1:0] w_cnt_dec;

    // One clock's worth of Galois steps: DATA_W single-bit updates, d[0] first.
    function automatic logic [CRC_W-1:0] f_step(
        input logic [CRC_W-1:0]  crc_in,
        input logic [DATA_W-1:0] d
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = 0; i < DATA_W; i++) begin
            fb = c[CRC_W-1] ^ d[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    // Outside CALC the next accepted word always starts a new frame, so the
    // step is taken from SEED and any stale register contents are ignored.
    assign w_base    = (r_state == S_CALC) ? r_crc : SEED;
    assign w_step    = f_step(w_base, DATA);
    assign w_cnt_dec = r_cnt - CNT_W'(1);

`ifdef CRC_FINAL_XOR_EN
    // Final inversion applies only to what leaves the block.
    assign w_crc_out = r_crc ^ {CRC_W{1'b1}};
`else
    assign w_crc_out = r_crc;
`endif

    // Frame sequencing, CRC accumulation and the serial readout.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_crc       <= SEED;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ACTIVE) begin
                        r_crc   <= w_step;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (ACTIVE) begin
                        r_crc <= w_step;
                    end else begin
                        // The MSB goes out in the same cycle as Valid.
                        r_state     <= S_SHIFT;
                        r_valid     <= 1'b1;
                        r_cnt       <= CNT_LAST;
                        r_ser_valid <= 1'b1;
                        r_ser_out   <= w_crc_out[CRC_W-1];
                    end
                end
                S_SHIFT: begin
                    if (ACTIVE) begin
                        // A new frame pre-empts the readout of the old one.
                        r_crc       <= w_step;
                        r_state     <= S_CALC;
                        r_cnt       <= '0;
                        r_ser_valid <= 1'b0;
                        r_ser_out   <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state     <= S_IDLE;
                        r_ser_valid <= 1'b0;
                        r_ser_out   <= 1'b0;
                    end else begin
                        r_cnt     <= w_cnt_dec;
                        r_ser_out <= w_crc_out[w_cnt_dec];
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ser_valid <= 1'b0;
                    r_ser_out   <= 1'b0;
                end
            endcase
        end
    end

    assign CRC       = w_crc_out;
    assign Valid     = r_valid;
    assign SER_OUT   = r_ser_out;
    assign SER_VALID = r_ser_valid;

endmodule

// File: tb/tb_crc_engine_param.sv
// tb_crc_engine_param
// Three engines share one clock and reset: defaults (bit-serial, seed 00),
// a seeded bit-serial one (seed FF) fed the same stream, and a byte-wide one.
// Expected CRCs come from polynomial remainder arithmetic:
//   crc = (seed * x^n + M(x) * x^8) mod (x^8 + x^2 + x + 1)
// with the first stream bit as the highest-degree coefficient of M(x).

module tb_crc_engine_param;

    logic       clk;
    logic       rst_n;
    logic       a1;
    logic       d1;
    logic       ap;
    logic [7:0] dp;

    logic [7:0] crc0, crc1, crcp;
    logic       v0, v1, vp;
    logic       so0, so1, sop;
    logic       sv0, sv1, svp;

    int n_cmp;
    int n_err;
    int n_valid0;

    crc_engine_param dut (
        .CLK(clk), .RST(rst_n), .DATA(d1), .ACTIVE(a1),
        .CRC(crc0), .Valid(v0), .SER_OUT(so0), .SER_VALID(sv0)
    );

    crc_engine_param #(.SEED(8'hFF)) dut_s (
        .CLK(clk), .RST(rst_n), .DATA(d1), .ACTIVE(a1),
        .CRC(crc1), .Valid(v1), .SER_OUT(so1), .SER_VALID(sv1)
    );

    crc_engine_param #(.DATA_W(8)) dut_p (
        .CLK(clk), .RST(rst_n), .DATA(dp), .ACTIVE(ap),
        .CRC(crcp), .Valid(vp), .SER_OUT(sop), .SER_VALID(svp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (v0 === 1'b1) n_valid0++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, required $finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] fin(input logic [7:0] r);
`ifdef CRC_FINAL_XOR_EN
        return ~r;
`else
        return r;
`endif
    endfunction

    function automatic logic [7:0] ref_crc(input logic [7:0] seed, input logic [63:0] d, input int n);
        logic [95:0] v;
        v = 96'(seed) << n;
        for (int i = 0; i < n; i++)
            if (d[i]) v[8 + n - 1 - i] = ~v[8 + n - 1 - i];
        for (int b = 95; b >= 8; b--)
            if (v[b]) v = v ^ (96'h107 << (b - 8));
        return v[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial frame into dut and dut_s, then full readout check.
    task automatic frame1(input logic [63:0] d, input int n);
        logic [7:0] e0, e1;
        for (int i = 0; i < n; i++) begin
            a1 = 1'b1;
            d1 = d[i];
            tick();
            chk("run_crc", crc0, fin(ref_crc(8'h00, d, i + 1)));
            chk("run_crc_seeded", crc1, fin(ref_crc(8'hFF, d, i + 1)));
            chk("run_valid", v0, 1'b0);
        end
        a1 = 1'b0;
        d1 = 1'b0;
        tick();
        e0 = fin(ref_crc(8'h00, d, n));
        e1 = fin(ref_crc(8'hFF, d, n));
        chk("valid", v0, 1'b1);
        chk("valid_seeded", v1, 1'b1);
        chk("final_crc", crc0, e0);
        chk("final_crc_seeded", crc1, e1);
        for (int k = 7; k >= 0; k--) begin
            chk("ser_valid", sv0, 1'b1);
            chk("ser_out", so0, e0[k]);
            chk("ser_out_seeded", so1, e1[k]);
            chk("crc_hold", crc0, e0);
            if (k != 7) chk("valid_once", v0, 1'b0);
            tick();
        end
        chk("ser_done", sv0, 1'b0);
        chk("ser_out_idle", so0, 1'b0);
        chk("valid_after", v0, 1'b0);
        chk("crc_idle_hold", crc0, e0);
    endtask

    // Byte-wide frame into dut_p.
    task automatic framep(input logic [63:0] d, input int nw);
        logic [7:0] e;
        for (int i = 0; i < nw; i++) begin
            ap = 1'b1;
            dp = d[8*i +: 8];
            tick();
            chk("par_run_crc", crcp, fin(ref_crc(8'h00, d, 8 * (i + 1))));
            chk("par_run_valid", vp, 1'b0);
        end
        ap = 1'b0;
        dp = 8'h00;
        tick();
        e = fin(ref_crc(8'h00, d, 8 * nw));
        chk("par_valid", vp, 1'b1);
        chk("par_final_crc", crcp, e);
        for (int k = 7; k >= 0; k--) begin
            chk("par_ser_valid", svp, 1'b1);
            chk("par_ser_out", sop, e[k]);
            tick();
        end
        chk("par_ser_done", svp, 1'b0);
        chk("par_valid_after", vp, 1'b0);
    endtask

    initial begin
        logic [63:0] rd;
        int          rn;
        n_cmp = 0;
        n_err = 0;
        n_valid0 = 0;
        rst_n = 1'b0;
        a1 = 1'b0;
        d1 = 1'b0;
        ap = 1'b0;
        dp = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_crc", crc0, fin(8'h00));
        chk("rst_crc_seeded", crc1, fin(8'hFF));
        chk("rst_valid", v0, 1'b0);
        chk("rst_ser_valid", sv0, 1'b0);
        chk("rst_ser_out", so0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Zero-word frame: ACTIVE never rises.
        n_valid0 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_valid", v0, 1'b0);
            chk("idle_ser_valid", sv0, 1'b0);
        end
        chk("idle_valid_count", n_valid0, 0);

        // Known vectors: 01 -> 89 (seed 00) and 01 from seed FF via model; 00 from seed FF -> F3.
        frame1(64'h01, 8);
        chk("vec_01", crc0, fin(8'h89));
        frame1(64'h00, 8);
        chk("vec_seed_ff_00", crc1, fin(8'hF3));

        // One-cycle frame.
        frame1(64'h1, 1);
        chk("one_cycle", crc0, fin(8'h07));

        // Parallel mode: one word 01 -> 89, same as bit-serial.
        framep(64'h01, 1);
        chk("par_vec_01", crcp, fin(8'h89));

        // Back-to-back: second frame aborts the readout of the first.
        n_valid0 = 0;
        for (int i = 0; i < 8; i++) begin
            a1 = 1'b1;
            d1 = (i == 0);
            tick();
        end
        a1 = 1'b0;
        d1 = 1'b0;
        tick();
        chk("b2b_valid1", v0, 1'b1);
        chk("b2b_crc1", crc0, fin(8'h89));
        tick();
        tick();
        chk("b2b_shifting", sv0, 1'b1);
        a1 = 1'b1;
        d1 = 1'b0;
        tick();
        chk("b2b_abort_ser_valid", sv0, 1'b0);
        chk("b2b_abort_valid", v0, 1'b0);
        chk("b2b_reseed", crc0, fin(ref_crc(8'h00, 64'h0, 1)));
        for (int i = 1; i < 8; i++) tick();
        a1 = 1'b0;
        tick();
        chk("b2b_valid2", v0, 1'b1);
        chk("b2b_crc2", crc0, fin(8'h00));
        for (int k = 0; k < 9; k++) tick();
        chk("b2b_ser_done", sv0, 1'b0);
        chk("b2b_valid_count", n_valid0, 2);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 3; i++) begin
            a1 = 1'b1;
            d1 = 1'b1;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_frame_crc", crc0, fin(8'h00));
        chk("rst_mid_frame_crc_seeded", crc1, fin(8'hFF));
        a1 = 1'b0;
        d1 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_mid_frame_valid", v0, 1'b0);

        // Asynchronous reset mid-shift.
        for (int i = 0; i < 8; i++) begin
            a1 = 1'b1;
            d1 = (i == 0);
            tick();
        end
        a1 = 1'b0;
        tick();
        tick();
        chk("pre_rst_shift", sv0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_shift_ser_valid", sv0, 1'b0);
        chk("rst_mid_shift_crc", crc0, fin(8'h00));
        chk("rst_mid_shift_valid", v0, 1'b0);
        chk("rst_mid_shift_ser_out", so0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ser_valid", sv0, 1'b0);

        // Randomised frames.
        for (int f = 0; f < 20; f++) begin
            rd = {$urandom, $urandom};
            rn = $urandom_range(1, 24);
            frame1(rd, rn);
        end
        for (int f = 0; f < 10; f++) begin
            rd = {$urandom, $urandom};
            rn = $urandom_range(1, 5);
            framep(rd, rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
